// File: rtl/clk_phase_gen.sv
// Multi-channel clock-enable generator: per-channel divide ratio and strobe phase,
// with shadowed configs applied at period boundaries, global hold and resync.
module clk_phase_gen #(
   parameter int NCH       = 4,
   parameter int CNT_W     = 8,
   parameter int RESET_DIV = 3,
   parameter int CH_W      = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             resync,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_phase,
   output logic [NCH-1:0]   strobe,
   output logic [NCH-1:0]   level,
   output logic [NCH-1:0]   cfg_pending
);

   // Phase beyond the period is clamped once here, shared by every channel.
   logic [CNT_W-1:0] wr_phase;
   assign wr_phase = (cfg_phase > cfg_div) ? cfg_div : cfg_phase;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] div;
      logic [CNT_W-1:0] phase;
      logic [CNT_W-1:0] shadow_div;
      logic [CNT_W-1:0] shadow_phase;
      logic             pend;
      logic             strobe_r;
      logic             level_r;
      logic             hit;
      logic             at_end;
      logic             take;
      logic             load;
      logic [CNT_W-1:0] src_div;
      logic [CNT_W-1:0] src_phase;
      logic [CNT_W:0]   level_lim;

      assign hit       = cfg_we && (cfg_ch == CH_W'(i));
      assign at_end    = enable && (cnt == div);
      // take: cycles that restart the counter; a same-cycle write bypasses the shadow.
      assign take      = resync || at_end || (!enable && pend);
      assign load      = take && (hit || pend);
      assign src_div   = hit ? cfg_div  : shadow_div;
      assign src_phase = hit ? wr_phase : shadow_phase;
      assign level_lim = ({1'b0, div} + (CNT_W+1)'(2)) >> 1;

      always_ff @(posedge clock) begin
         if (!reset) begin
            cnt          <= '0;
            div          <= CNT_W'(RESET_DIV);
            phase        <= '0;
            shadow_div   <= '0;
            shadow_phase <= '0;
            pend         <= 1'b0;
            strobe_r     <= 1'b0;
            level_r      <= 1'b0;
         end else begin
            strobe_r <= !resync && enable && (cnt == phase);
            if (resync) begin
               level_r <= 1'b0;
            end else if (enable) begin
               level_r <= ({1'b0, cnt} < level_lim);
            end
            if (take) begin
               cnt  <= '0;
               pend <= 1'b0;
               if (load) begin
                  div   <= src_div;
                  phase <= src_phase;
               end
            end else begin
               // cnt != div here, so the increment cannot overflow.
               if (enable) begin
                  cnt <= cnt + CNT_W'(1);
               end
               if (hit) begin
                  shadow_div   <= cfg_div;
                  shadow_phase <= wr_phase;
                  pend         <= 1'b1;
               end
            end
         end
      end

      assign strobe[i]      = strobe_r;
      assign level[i]       = level_r;
      assign cfg_pending[i] = pend;
   end

endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed and randomised bench for clk_phase_gen: a cycle model predicts the
// outputs of every edge into a queue; directed constants pin the key scenarios.
module tb_clk_phase_gen;
   localparam int NCH   = 4;
   localparam int CNT_W = 8;
   localparam int CH_W  = 2;
   localparam int VW    = 3 * NCH;

   logic             clock;
   logic             reset;
   logic             enable;
   logic             resync;
   logic             cfg_we;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic [CNT_W-1:0] cfg_phase;
   logic [NCH-1:0]   strobe;
   logic [NCH-1:0]   level;
   logic [NCH-1:0]   cfg_pending;

   clk_phase_gen #(.NCH(NCH), .CNT_W(CNT_W), .RESET_DIV(3), .CH_W(CH_W)) dut (
      .clock(clock), .reset(reset), .enable(enable), .resync(resync),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
      .strobe(strobe), .level(level), .cfg_pending(cfg_pending)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // reference model state
   int m_cnt [NCH];
   int m_div [NCH];
   int m_ph  [NCH];
   int m_sdiv[NCH];
   int m_sph [NCH];
   int m_pend[NCH];
   int m_str [NCH];
   int m_lvl [NCH];

   logic [VW-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [VW-1:0] e;
      int wdiv, wph, hit, bnd;
      wdiv = int'(cfg_div);
      wph  = (int'(cfg_phase) > wdiv) ? wdiv : int'(cfg_phase);
      for (int i = 0; i < NCH; i++) begin
         if (!reset) begin
            m_cnt[i] = 0; m_div[i] = 3; m_ph[i] = 0; m_sdiv[i] = 0; m_sph[i] = 0;
            m_pend[i] = 0; m_str[i] = 0; m_lvl[i] = 0;
         end else begin
            hit = (cfg_we && int'(cfg_ch) == i) ? 1 : 0;
            bnd = (enable && m_cnt[i] == m_div[i]) ? 1 : 0;
            if (resync) begin
               m_str[i] = 0; m_lvl[i] = 0;
            end else if (enable) begin
               m_str[i] = (m_cnt[i] == m_ph[i]) ? 1 : 0;
               m_lvl[i] = (m_cnt[i] < (m_div[i] + 2) / 2) ? 1 : 0;
            end else begin
               m_str[i] = 0;
            end
            if (resync || bnd || (!enable && m_pend[i] != 0)) begin
               if (hit != 0) begin
                  m_div[i] = wdiv; m_ph[i] = wph;
               end else if (m_pend[i] != 0) begin
                  m_div[i] = m_sdiv[i]; m_ph[i] = m_sph[i];
               end
               m_cnt[i] = 0; m_pend[i] = 0;
            end else begin
               if (enable) m_cnt[i] = m_cnt[i] + 1;
               if (hit != 0) begin
                  m_sdiv[i] = wdiv; m_sph[i] = wph; m_pend[i] = 1;
               end
            end
         end
         e[i]         = m_str[i][0];
         e[NCH + i]   = m_lvl[i][0];
         e[2*NCH + i] = m_pend[i][0];
      end
      exp_q.push_back(e);
   endtask

   // driver: predict, clock one edge, then compare away from the edge
   task automatic step();
      logic [VW-1:0] e;
      model_edge();
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("sb_outputs", 32'({cfg_pending, level, strobe}), 32'(e));
      end
   endtask

   task automatic wr(input int ch, input int dv, input int ph);
      cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(dv); cfg_phase = CNT_W'(ph);
      step();
      cfg_we = 1'b0;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i] = 0; m_div[i] = 3; m_ph[i] = 0; m_sdiv[i] = 0; m_sph[i] = 0;
         m_pend[i] = 0; m_str[i] = 0; m_lvl[i] = 0;
      end
      reset = 1'b0; enable = 1'b1; resync = 1'b0; cfg_we = 1'b0;
      cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
      @(negedge clock);

      // 1: reset then free-running D=4 on every channel
      run(2);
      check("reset_strobe", 32'(strobe), 32'd0);
      check("reset_level", 32'(level), 32'd0);
      check("reset_pending", 32'(cfg_pending), 32'd0);
      reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         check("t1_strobe", 32'(strobe), (k % 4 == 1) ? 32'hF : 32'h0);
         check("t1_level", 32'(level), (k % 4 == 1 || k % 4 == 2) ? 32'hF : 32'h0);
      end

      // 2: ch1 div=2 phase=1 written while cnt=1
      step();
      wr(1, 2, 1);
      check("t2_pending", 32'(cfg_pending), 32'h2);
      run(14);
      check("t2_cleared", 32'(cfg_pending[1]), 32'd0);

      // 3: ch2 div=4 phase=9 clamps to the last count
      wr(2, 4, 9);
      check("t3_pending", 32'(cfg_pending[2]), 32'd1);
      run(16);

      // 4: hold for 3 cycles mid-period
      step();
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("t4_strobe_held", 32'(strobe), 32'd0);
      end
      enable = 1'b1;
      run(12);

      // 5: ch0 D=3, ch3 D=5 then resync lines them up
      wr(0, 2, 0);
      step();
      wr(3, 4, 0);
      run(13);
      resync = 1'b1;
      step();
      resync = 1'b0;
      check("t5_resync_strobe", 32'(strobe), 32'd0);
      check("t5_resync_level", 32'(level), 32'd0);
      check("t5_resync_pending", 32'(cfg_pending), 32'd0);
      step();
      check("t5_coincide", 32'({strobe[3], strobe[0]}), 32'h3);
      run(6);

      // D=1 on ch1, and a write during resync bypassing the shadow
      wr(1, 0, 3);
      run(8);
      check("d1_level", 32'(level[1]), 32'd1);
      check("d1_strobe", 32'(strobe[1]), 32'd1);
      resync = 1'b1;
      wr(2, 1, 1);
      resync = 1'b0;
      check("resync_bypass_pend", 32'(cfg_pending[2]), 32'd0);
      run(6);

      // max ratio on ch3 wraps cleanly; random traffic elsewhere
      wr(3, 255, 254);
      run(260);
      for (int k = 0; k < 300; k++) begin
         enable    = ($urandom_range(0, 7) != 0);
         resync    = ($urandom_range(0, 59) == 0);
         cfg_we    = ($urandom_range(0, 11) == 0);
         cfg_ch    = CH_W'($urandom_range(0, NCH - 1));
         cfg_div   = CNT_W'(($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 6));
         cfg_phase = CNT_W'($urandom_range(0, 8));
         step();
      end
      enable = 1'b1; resync = 1'b0; cfg_we = 1'b0;
      run(4);

      // 6: reset mid-operation discards a pending write
      wr(1, 6, 2);
      check("t6_pending_set", 32'(cfg_pending[1]), 32'd1);
      reset = 1'b0;
      step();
      check("t6_strobe", 32'(strobe), 32'd0);
      check("t6_level", 32'(level), 32'd0);
      check("t6_pending", 32'(cfg_pending), 32'd0);
      reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         check("t6_d4_strobe", 32'(strobe), (k % 4 == 1) ? 32'hF : 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
